// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader.
// Header gives a little-endian word count; words arrive LSB first.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  localparam int          IW      = $clog2(DEPTH) + 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, HDR, LOAD, WRITE, DONE, ERROR
  } state_t;

  state_t         state, state_n;
  logic [1:0]     cnt;
  logic [7:0]     hdr_lo;
  logic [15:0]    n_words;
  logic [23:0]    acc;
  logic [IW-1:0]  idx;
  logic           xfer;
  logic           last_word;
  logic [15:0]    hdr_n;

  assign xfer      = byte_valid & byte_ready;
  assign hdr_n     = {byte_in, hdr_lo};
  assign last_word = (32'(idx) == (32'(n_words) - 32'd1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = HDR;
      HDR: begin
        if (xfer && cnt == 2'd1) begin
          if (hdr_n == 16'd0)               state_n = DONE;
          else if (32'(hdr_n) > DEPTH_W)    state_n = ERROR;
          else                              state_n = LOAD;
        end
      end
      LOAD:  if (xfer && cnt == 2'd3) state_n = WRITE;
      WRITE: state_n = last_word ? DONE : LOAD;
      DONE:  if (start) state_n = HDR;
      ERROR: if (start) state_n = HDR;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      hdr_lo  <= 8'd0;
      n_words <= 16'd0;
      acc     <= 24'd0;
      idx     <= '0;
      wr_addr <= BASE_ADDR;
      wr_data <= 32'd0;
    end else begin
      state <= state_n;
      // Entering a new session restarts byte and word counting.
      if (state_n == HDR && state != HDR) begin
        cnt <= 2'd0;
        idx <= '0;
      end else if (xfer && state == HDR) begin
        if (cnt == 2'd0) begin
          hdr_lo <= byte_in;
          cnt    <= 2'd1;
        end else begin
          n_words <= hdr_n;
          cnt     <= 2'd0;
        end
      end else if (xfer && state == LOAD) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          wr_data <= {byte_in, acc};
          wr_addr <= BASE_ADDR + (32'(idx) << 2);
        end else begin
          acc[cnt*8 +: 8] <= byte_in;
        end
      end else if (state == WRITE && !last_word) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign byte_ready = (state == HDR) || (state == LOAD);
  assign wr_en      = (state == WRITE);
  assign busy       = (state == HDR) || (state == LOAD) || (state == WRITE);
  assign done       = (state == DONE);
  assign err        = (state == ERROR);
  assign cpu_hold   = (state != DONE);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024: instruction memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded word; word aligned.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 byte_in  input  8  incoming program byte.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 wr_en  output  1  instruction memory write strobe, one cycle per word.
REQ-010 wr_addr  output  32  byte address of the word being written; bits [1:0] always 0.
REQ-011 wr_data  output  32  instruction word being written.
REQ-012 busy  output  1  session in progress (HDR, LOAD or WRITE).
REQ-013 done  output  1  load completed successfully.
REQ-014 err  output  1  header word count exceeded DEPTH.
REQ-015 cpu_hold  output  1  holds the CPU/PC in reset; deasserted only in DONE.

Function
REQ-016 States: IDLE, HDR, LOAD, WRITE, DONE, ERROR.
REQ-017 Byte transfer occurs at a rising edge where byte_valid=1 and byte_ready=1; byte_ready is 1 only in HDR and LOAD.
REQ-018 IDLE: start=1 -> HDR; byte counter and word index cleared.
REQ-019 HDR: accepts 2 bytes, little-endian, forming 16-bit word count N.
REQ-020 After the 2nd header byte: N=0 -> DONE; N>DEPTH -> ERROR; else -> LOAD.
REQ-021 LOAD: accepts 4 bytes, little-endian (first byte -> wr_data[7:0], fourth -> [31:24]).
REQ-022 On acceptance of the 4th byte at edge k, next state is WRITE; wr_en=1 for exactly the cycle between edges k and k+1.
REQ-023 In WRITE: wr_addr = BASE_ADDR + 4*idx, idx = 0..N-1 in order; wr_data stable throughout; byte_ready=0.
REQ-024 WRITE exit: idx=N-1 -> DONE; else idx increments, -> LOAD.
REQ-025 Address arithmetic is 32-bit, modulo 2^32; idx width is ceil(log2(DEPTH))+1 bits.
REQ-026 wr_en=0, and wr_addr/wr_data hold their last value, in every state other than WRITE.
REQ-027 DONE: done=1, cpu_hold=0, busy=0; held until rst or start.
REQ-028 ERROR: err=1, cpu_hold=1, busy=0, no writes; held until rst or start.
REQ-029 start=1 in DONE or ERROR -> HDR, clearing done/err the next cycle and reasserting cpu_hold.
REQ-030 start is ignored in HDR, LOAD and WRITE.
REQ-031 byte_valid with byte_ready=0 is not consumed; the source holds the byte.
REQ-032 Idle cycles (byte_valid=0) in HDR or LOAD are allowed indefinitely; partial bytes are retained.

Reset
REQ-033 rst=1 at a rising edge forces IDLE, from any state, including mid-word or mid-WRITE.
REQ-034 Reset values: byte_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, err=0, cpu_hold=1.
REQ-035 A partially assembled word is discarded on reset and never written.
REQ-036 rst has priority over start in the same cycle.

Verification
REQ-037 start; bytes 02 00, 13 00 00 00, 93 00 10 00 -> writes (0x0, 0x00000013) then (0x4, 0x00100093); done=1, cpu_hold=0.
REQ-038 start; header 00 00 -> DONE within 1 cycle of the 2nd byte; no wr_en pulse.
REQ-039 DEPTH=1024, header 01 04 (N=1025) -> err=1, cpu_hold=1, byte_ready=0; no wr_en; start then recovers to HDR.
REQ-040 Valid stream with random byte_valid gaps, N=3 -> identical writes to the gap-free case; wr_en never high with byte_ready=1.
REQ-041 rst after 2 data bytes of word 1 -> IDLE, no write for word 1; a fresh session writes from BASE_ADDR.
REQ-042 BASE_ADDR=32'h0000_0100, N=2 -> wr_addr 0x100, 0x104; start pulses mid-LOAD have no effect.
